// File: rtl/ariane_axi_err_slave_pkg.sv
// Shared AXI response codes, error-slave constants and FSM state types.
package ariane_axi_err_slave_pkg;

   localparam int unsigned LenWidth  = 8;
   localparam int unsigned RespWidth = 2;

   typedef enum logic [RespWidth-1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   // Recognisable pattern so software can spot reads that hit a hole.
   localparam logic [63:0] ErrSlaveData = 64'hBADC_AB1E_BADC_AB1E;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_e;

   typedef enum logic {
      R_IDLE,
      R_DATA
   } r_state_e;

endpackage

// File: rtl/ariane_axi_err_slave.sv
// AXI4 terminating responder for unmapped address ranges: accepts any burst,
// drains write data and answers every transaction with an error response.
module ariane_axi_err_slave
   import ariane_axi_err_slave_pkg::*;
#(
   parameter int unsigned          IdWidth   = 5,
   parameter int unsigned          DataWidth = 64,
   parameter axi_resp_e            Resp      = RESP_DECERR,
   parameter logic [DataWidth-1:0] RespData  = DataWidth'(ErrSlaveData)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 aw_valid_i,
   output logic                 aw_ready_o,
   input  logic [IdWidth-1:0]   aw_id_i,
   input  logic                 w_valid_i,
   output logic                 w_ready_o,
   input  logic                 w_last_i,
   output logic                 b_valid_o,
   input  logic                 b_ready_i,
   output logic [IdWidth-1:0]   b_id_o,
   output logic [RespWidth-1:0] b_resp_o,
   input  logic                 ar_valid_i,
   output logic                 ar_ready_o,
   input  logic [IdWidth-1:0]   ar_id_i,
   input  logic [LenWidth-1:0]  ar_len_i,
   output logic                 r_valid_o,
   input  logic                 r_ready_i,
   output logic [IdWidth-1:0]   r_id_o,
   output logic [DataWidth-1:0] r_data_o,
   output logic [RespWidth-1:0] r_resp_o,
   output logic                 r_last_o
);

   w_state_e              w_state_q;
   r_state_e              r_state_q;
   logic [IdWidth-1:0]    aw_id_q;
   logic [LenWidth-1:0]   r_cnt_q;

   // Write channel: take AW, swallow beats up to w_last, then hold B until accepted.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         w_state_q  <= W_IDLE;
         aw_ready_o <= 1'b1;
         w_ready_o  <= 1'b0;
         b_valid_o  <= 1'b0;
         b_id_o     <= '0;
         b_resp_o   <= '0;
         aw_id_q    <= '0;
      end else begin
         case (w_state_q)
            W_IDLE: begin
               if (aw_valid_i) begin
                  aw_id_q    <= aw_id_i;
                  aw_ready_o <= 1'b0;
                  w_ready_o  <= 1'b1;
                  w_state_q  <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_valid_i && w_last_i) begin
                  w_ready_o <= 1'b0;
                  b_valid_o <= 1'b1;
                  b_id_o    <= aw_id_q;
                  b_resp_o  <= Resp;
                  w_state_q <= W_RESP;
               end
            end
            W_RESP: begin
               if (b_ready_i) begin
                  b_valid_o  <= 1'b0;
                  b_id_o     <= '0;
                  b_resp_o   <= '0;
                  aw_ready_o <= 1'b1;
                  w_state_q  <= W_IDLE;
               end
            end
            default: begin
               w_state_q <= W_IDLE;
            end
         endcase
      end
   end

   // Read channel: take AR, then stream len+1 constant error beats; counter never wraps.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state_q  <= R_IDLE;
         ar_ready_o <= 1'b1;
         r_valid_o  <= 1'b0;
         r_id_o     <= '0;
         r_data_o   <= '0;
         r_resp_o   <= '0;
         r_last_o   <= 1'b0;
         r_cnt_q    <= '0;
      end else begin
         case (r_state_q)
            R_IDLE: begin
               if (ar_valid_i) begin
                  ar_ready_o <= 1'b0;
                  r_valid_o  <= 1'b1;
                  r_id_o     <= ar_id_i;
                  r_data_o   <= RespData;
                  r_resp_o   <= Resp;
                  r_last_o   <= (ar_len_i == LenWidth'(0));
                  r_cnt_q    <= ar_len_i;
                  r_state_q  <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_ready_i) begin
                  if (r_cnt_q == LenWidth'(0)) begin
                     ar_ready_o <= 1'b1;
                     r_valid_o  <= 1'b0;
                     r_id_o     <= '0;
                     r_data_o   <= '0;
                     r_resp_o   <= '0;
                     r_last_o   <= 1'b0;
                     r_state_q  <= R_IDLE;
                  end else begin
                     r_cnt_q  <= r_cnt_q - LenWidth'(1);
                     r_last_o <= (r_cnt_q == LenWidth'(1));
                  end
               end
            end
            default: begin
               r_state_q <= R_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ariane_axi_err_slave.md
Name: ariane_axi_err_slave

Overview:
- AXI4 terminating responder for address ranges that the SoC memory map leaves unmapped (holes between Debug, CLINT, PLIC, ExtIO and DRAM, and unused ExtIO sub-windows).
- Attached as the default port of the crossbar and of the ExtIO demux, on the slave side (IdWidthSlave IDs).
- Accepts any burst, drains write data, and answers every transaction with an error response so that the hart takes an access fault instead of hanging.

Parameters:
- IdWidth, 5, AXI ID width on the slave side (ariane_soc::IdWidthSlave).
- DataWidth, 64, R data width.
- Resp, 2'b11, response code returned (DECERR; 2'b10 SLVERR allowed).
- RespData, 64'hBADC_AB1E_BADC_AB1E, constant R data pattern.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- aw_valid_i  in  1  write address valid.
- aw_ready_o  out  1  write address ready.
- aw_id_i  in  IdWidth  write ID.
- w_valid_i  in  1  write data valid.
- w_ready_o  out  1  write data ready.
- w_last_i  in  1  last write beat.
- b_valid_o  out  1  write response valid.
- b_ready_i  in  1  write response ready.
- b_id_o  out  IdWidth  write response ID.
- b_resp_o  out  2  write response code.
- ar_valid_i  in  1  read address valid.
- ar_ready_o  out  1  read address ready.
- ar_id_i  in  IdWidth  read ID.
- ar_len_i  in  8  read burst length minus 1.
- r_valid_o  out  1  read data valid.
- r_ready_i  in  1  read data ready.
- r_id_o  out  IdWidth  read data ID.
- r_data_o  out  DataWidth  read data.
- r_resp_o  out  2  read response code.
- r_last_o  out  1  last read beat.

Behaviour:
- One clock domain. Reset is asynchronous, active-low (rst_ni). After reset both FSMs are IDLE, all valid outputs are 0, aw_ready_o and ar_ready_o are 1, and the ID and counter registers are 0.
- Read and write channels are fully independent; each has at most one outstanding transaction.
- No output depends combinationally on an input of the same channel: every ready and valid is decoded from registered state.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: aw_ready_o=1. On aw_valid_i, capture aw_id_i and go to W_DATA next cycle.
  - W_DATA: w_ready_o=1. Every beat with w_valid_i is consumed and its data discarded. A beat with w_last_i=1 moves the FSM to W_RESP. aw_len is not checked; w_last_i alone terminates the burst.
  - W_RESP: b_valid_o=1, b_id_o=captured ID, b_resp_o=Resp. b_valid_o holds until b_ready_i, then the FSM returns to W_IDLE.
  - W data that arrives before AW is not accepted (w_ready_o=0 outside W_DATA).
  - Minimum AW-to-B latency: 2 cycles (AW handshake in cycle n, single W beat in n+1, B valid in n+2).
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: ar_ready_o=1. On ar_valid_i, capture ar_id_i and load the 8-bit counter with ar_len_i.
  - R_DATA: r_valid_o=1, r_data_o=RespData, r_resp_o=Resp, r_id_o=captured ID, r_last_o=(counter==0).
  - On each r_valid_o & r_ready_i, the counter decrements. On the beat with r_last_o, the FSM returns to R_IDLE.
  - ar_len_i=255 produces exactly 256 beats; the counter never wraps.
  - First R beat is visible the cycle after the AR handshake.
- Outputs hold stable while valid is high and ready is low (AXI stability rule).
- Reset asserted mid-burst aborts immediately to the reset values. No response is owed after reset.
- Outside W_RESP and R_DATA, b_id_o, b_resp_o, r_id_o, r_data_o, r_resp_o and r_last_o drive 0.

Decomposition:
- Add to ariane_soc:
  - AXI response codes (RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR) as a 2-bit typedef.
  - the ErrSlaveData constant.
- The write and read FSMs live in this single module; no sub-module is warranted.
- Top level instantiates this block on the crossbar default port and on the ExtIO demux default port.

Test Plan:
- Single write: AW id=5, one W beat with last=1, b_ready=1 -> B valid 2 cycles after AW, b_id=5, b_resp=2'b11, exactly one B.
- Read burst: AR id=3, len=3, r_ready=1 -> 4 consecutive beats of 64'hBADC_AB1E_BADC_AB1E, id=3, resp=2'b11, r_last only on the 4th beat.
- Backpressure: AR len=1 with r_ready toggling 0,1,0,0,1 -> data/id/last stable while stalled, exactly 2 beats, ar_ready=0 until the last handshake.
- Concurrent: AW id=1 (len 7, 8 W beats) and AR id=2 (len 255) in the same cycle -> B after the 8th W beat, 256 R beats, channels do not block each other.
- Ordering: W beats presented 3 cycles before AW -> w_ready=0 until the FSM is in W_DATA, then beats are accepted and B follows.
- Reset mid-burst: deassert rst_ni during beat 2 of a len=7 read -> r_valid=0 immediately, ar_ready=1 after reset release, a new AR len=0 returns one beat with last=1.
